proc_core: RTL and testbench

PROC_CORE -- requirements
Module: proc_core

---
 rtl/proc_core_pkg.sv | 16 +
 rtl/proc_step.sv | 20 ++
 rtl/proc_core.sv | 135 +++++++++++++
 tb/tb_proc_core.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_core_pkg.sv
// Shared encodings for the proc_core iteration engine.
// Holds the host command codes and the status/state encoding used by proc_core.
package proc_core_pkg;

    localparam logic [3:0] CMD_START_C = 4'd1;
    localparam logic [3:0] CMD_ACK_C   = 4'd2;
    localparam logic [3:0] CMD_ABORT_C = 4'd3;

    // State encoding doubles as the proc_status value seen by the host.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RUN      = 4'd1,
        ST_COMPLETE = 4'd2
    } state_e;

endpackage

// File: rtl/proc_step.sv
// One iteration of the recurrence: x' = x*c1 + c2, sum' = sum + x, pow' = pow + x*x.
// Ports: x_i/c1_i/c2_i/sum_i/pow_i in; x_o/sum_o/pow_o out. All arithmetic mod 2^64.
module proc_step (
    input  logic [63:0] x_i,
    input  logic [63:0] c1_i,
    input  logic [63:0] c2_i,
    input  logic [63:0] sum_i,
    input  logic [63:0] pow_i,
    output logic [63:0] x_o,
    output logic [63:0] sum_o,
    output logic [63:0] pow_o
);

    always_comb begin
        x_o   = x_i * c1_i + c2_i;
        sum_o = sum_i + x_i;
        pow_o = pow_i + x_i * x_i;
    end

endmodule

// File: rtl/proc_core.sv
// Host-driven iteration engine: IDLE/RUN/COMPLETE FSM, iteration counter, input snapshots.
// Ports: clk, nRESET (async low), proc_cmd/niter/constK/const1/const2 in; proc_status, sums out.
module proc_core
    import proc_core_pkg::*;
#(
    parameter logic [3:0] CMD_START = CMD_START_C,
    parameter logic [3:0] CMD_ACK   = CMD_ACK_C,
    parameter logic [3:0] CMD_ABORT = CMD_ABORT_C
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic [3:0]  proc_cmd,
    input  logic [31:0] niter,
    input  logic [63:0] constK,
    input  logic [63:0] const1,
    input  logic [63:0] const2,
    output logic [3:0]  proc_status,
    output logic [63:0] proc_sum_dout,
    output logic [63:0] proc_pow_sum_dout
);

    state_e      state_q, state_d;
    logic [31:0] niter_q, niter_d;
    logic [31:0] cnt_q, cnt_d;
    logic [63:0] c1_q, c1_d;
    logic [63:0] c2_q, c2_d;
    logic [63:0] x_q, x_d;
    logic [63:0] sum_q, sum_d;
    logic [63:0] pow_q, pow_d;
    logic [63:0] sum_out_q, sum_out_d;
    logic [63:0] pow_out_q, pow_out_d;

    logic [63:0] x_nxt, sum_nxt, pow_nxt;

    proc_step u_step (
        .x_i   (x_q),
        .c1_i  (c1_q),
        .c2_i  (c2_q),
        .sum_i (sum_q),
        .pow_i (pow_q),
        .x_o   (x_nxt),
        .sum_o (sum_nxt),
        .pow_o (pow_nxt)
    );

    always_comb begin
        state_d   = state_q;
        niter_d   = niter_q;
        cnt_d     = cnt_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        x_d       = x_q;
        sum_d     = sum_q;
        pow_d     = pow_q;
        sum_out_d = sum_out_q;
        pow_out_d = pow_out_q;
        unique case (state_q)
            ST_IDLE: begin
                if (proc_cmd == CMD_START) begin
                    niter_d = niter;
                    c1_d    = const1;
                    c2_d    = const2;
                    x_d     = constK;
                    cnt_d   = '0;
                    sum_d   = '0;
                    pow_d   = '0;
                    if (niter == 32'd0) begin
                        state_d   = ST_COMPLETE;
                        sum_out_d = '0;
                        pow_out_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (proc_cmd == CMD_ABORT) begin
                    state_d   = ST_IDLE;
                    sum_out_d = '0;
                    pow_out_d = '0;
                end else begin
                    x_d   = x_nxt;
                    sum_d = sum_nxt;
                    pow_d = pow_nxt;
                    cnt_d = cnt_q + 32'd1;
                    // Last iteration: publish this cycle's accumulation.
                    if (cnt_q == niter_q - 32'd1) begin
                        state_d   = ST_COMPLETE;
                        sum_out_d = sum_nxt;
                        pow_out_d = pow_nxt;
                    end
                end
            end
            ST_COMPLETE: begin
                if (proc_cmd == CMD_ACK) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= ST_IDLE;
            niter_q   <= '0;
            cnt_q     <= '0;
            c1_q      <= '0;
            c2_q      <= '0;
            x_q       <= '0;
            sum_q     <= '0;
            pow_q     <= '0;
            sum_out_q <= '0;
            pow_out_q <= '0;
        end else begin
            state_q   <= state_d;
            niter_q   <= niter_d;
            cnt_q     <= cnt_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            x_q       <= x_d;
            sum_q     <= sum_d;
            pow_q     <= pow_d;
            sum_out_q <= sum_out_d;
            pow_out_q <= pow_out_d;
        end
    end

    assign proc_status       = state_q;
    assign proc_sum_dout     = sum_out_q;
    assign proc_pow_sum_dout = pow_out_q;

endmodule

// File: tb/tb_proc_core.sv
// Self-checking bench for proc_core against a plain-arithmetic recurrence model.
// Directed corner cases plus randomized runs with inputs scrambled during RUN.
module tb_proc_core;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_RUN  = 4'd1;
    localparam logic [3:0] S_CMPL = 4'd2;
    localparam logic [3:0] C_START = 4'd1;
    localparam logic [3:0] C_ACK   = 4'd2;
    localparam logic [3:0] C_ABORT = 4'd3;

    logic        clk = 1'b0;
    logic        nRESET = 1'b0;
    logic [3:0]  proc_cmd = 4'd0;
    logic [31:0] niter = '0;
    logic [63:0] constK = '0;
    logic [63:0] const1 = '0;
    logic [63:0] const2 = '0;
    logic [3:0]  proc_status;
    logic [63:0] proc_sum_dout;
    logic [63:0] proc_pow_sum_dout;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [63:0] m_sum, m_pow;

    proc_core dut (
        .clk               (clk),
        .nRESET            (nRESET),
        .proc_cmd          (proc_cmd),
        .niter             (niter),
        .constK            (constK),
        .const1            (const1),
        .const2            (const2),
        .proc_status       (proc_status),
        .proc_sum_dout     (proc_sum_dout),
        .proc_pow_sum_dout (proc_pow_sum_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: iterate x_{i+1} = x_i*c1 + c2 and accumulate, all mod 2^64.
    task automatic model(input logic [63:0] k, input logic [63:0] c1,
                         input logic [63:0] c2, input int unsigned n,
                         output logic [63:0] s, output logic [63:0] p);
        logic [63:0] x;
        x = k;
        s = '0;
        p = '0;
        for (int unsigned i = 0; i < n; i++) begin
            s = s + x;
            p = p + x * x;
            x = x * c1 + c2;
        end
    endtask

    function automatic logic [3:0] rand_noabort();
        logic [3:0] v;
        v = 4'($urandom_range(0, 15));
        if (v == C_ABORT) v = 4'd0;
        return v;
    endfunction

    task automatic ack_check(input string tag);
        logic [63:0] s0, p0;
        s0 = proc_sum_dout;
        p0 = proc_pow_sum_dout;
        @(negedge clk);
        proc_cmd = C_ACK;
        @(posedge clk);
        #1;
        chk({tag, "_ack_state"}, 64'(proc_status), 64'(S_IDLE));
        chk({tag, "_ack_sum"}, proc_sum_dout, s0);
        chk({tag, "_ack_pow"}, proc_pow_sum_dout, p0);
    endtask

    task automatic run_check(input string tag, input logic [63:0] k,
                             input logic [63:0] c1, input logic [63:0] c2,
                             input int unsigned n, input bit scramble,
                             input bit do_ack);
        int unsigned runs;
        model(k, c1, c2, n, m_sum, m_pow);
        @(negedge clk);
        constK   = k;
        const1   = c1;
        const2   = c2;
        niter    = n;
        proc_cmd = C_START;
        @(posedge clk);
        #1;
        chk({tag, "_first"}, 64'(proc_status), 64'((n == 0) ? S_CMPL : S_RUN));
        if (scramble) begin
            constK = {$urandom, $urandom};
            const1 = {$urandom, $urandom};
            const2 = {$urandom, $urandom};
            niter  = $urandom_range(1, 100);
        end
        runs = 0;
        while (proc_status == S_RUN && runs < n + 4) begin
            @(negedge clk);
            if (scramble) proc_cmd = rand_noabort();
            @(posedge clk);
            #1;
            runs++;
        end
        chk({tag, "_runs"}, 64'(runs), 64'(n));
        chk({tag, "_state"}, 64'(proc_status), 64'(S_CMPL));
        chk({tag, "_sum"}, proc_sum_dout, m_sum);
        chk({tag, "_pow"}, proc_pow_sum_dout, m_pow);
        if (do_ack) ack_check(tag);
    endtask

    initial begin
        #2;
        chk("rst_state", 64'(proc_status), 64'(S_IDLE));
        chk("rst_sum", proc_sum_dout, 64'd0);
        chk("rst_pow", proc_pow_sum_dout, 64'd0);
        @(negedge clk);
        nRESET   = 1'b1;
        proc_cmd = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_unknown", 64'(proc_status), 64'(S_IDLE));

        run_check("pow2", 64'd1, 64'd2, 64'd0, 4, 1'b0, 1'b1);
        run_check("wrap", 64'h1_0000_0000, 64'd1, 64'd0, 1, 1'b0, 1'b1);
        run_check("zero", 64'd7, 64'd3, 64'd5, 0, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            run_check("rand", {$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, $urandom_range(1, 40), 1'b1, 1'b1);
        end

        // Abort mid-run, then a fresh run with the same constants.
        @(negedge clk);
        constK   = 64'd3;
        const1   = 64'd1;
        const2   = 64'd1;
        niter    = 32'd1000;
        proc_cmd = C_START;
        repeat (11) @(posedge clk);
        #1;
        chk("abort_pre", 64'(proc_status), 64'(S_RUN));
        @(negedge clk);
        proc_cmd = C_ABORT;
        @(posedge clk);
        #1;
        chk("abort_state", 64'(proc_status), 64'(S_IDLE));
        chk("abort_sum", proc_sum_dout, 64'd0);
        chk("abort_pow", proc_pow_sum_dout, 64'd0);
        run_check("rerun", 64'd3, 64'd1, 64'd1, 1000, 1'b0, 1'b0);

        // COMPLETE must ignore a lingering START.
        repeat (20) begin
            @(negedge clk);
            proc_cmd = C_START;
            @(posedge clk);
            #1;
            chk("hold_cmpl", 64'(proc_status), 64'(S_CMPL));
        end
        ack_check("hold");
        repeat (5) @(posedge clk);
        #1;
        chk("ack_stay", 64'(proc_status), 64'(S_IDLE));
        chk("ack_stay_sum", proc_sum_dout, m_sum);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        constK   = 64'd9;
        const1   = 64'd5;
        const2   = 64'd2;
        niter    = 32'd50;
        proc_cmd = C_START;
        repeat (6) @(posedge clk);
        #3;
        nRESET = 1'b0;
        #1;
        chk("arst_state", 64'(proc_status), 64'(S_IDLE));
        chk("arst_sum", proc_sum_dout, 64'd0);
        chk("arst_pow", proc_pow_sum_dout, 64'd0);
        proc_cmd = 4'd0;
        @(negedge clk);
        nRESET = 1'b1;
        run_check("post_rst", 64'd9, 64'd5, 64'd2, 50, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
